// File: rtl/pawn_move_exec_if.sv
// Request, checker and response bundle of the pawn move executor.
// The master side is the environment: it issues requests and plays the pawn-move checker.
interface pawn_move_exec_if;
    logic                  req_valid;
    logic                  req_ready;
    logic [2:0]            req_row;
    logic [2:0]            req_col;
    logic [1:0]            req_dir;
    logic [2:0]            chk_row;
    logic [2:0]            chk_col;
    logic                  chk_color;
    logic [7:0][7:0][4:0]  chk_board;
    logic [4:0]            chk_allow;
    logic                  resp_valid;
    logic [1:0]            resp_code;

    modport master (
        output req_valid, req_row, req_col, req_dir, chk_allow,
        input  req_ready, chk_row, chk_col, chk_color, chk_board, resp_valid, resp_code
    );

    modport slave (
        input  req_valid, req_row, req_col, req_dir, chk_allow,
        output req_ready, chk_row, chk_col, chk_color, chk_board, resp_valid, resp_code
    );
endinterface

// File: rtl/pawn_move_exec.sv
// Pawn move executor: owns the 8x8 board, consults the external checker, commits legal moves.
// Optional feature macro: PAWN_PROMOTE_EN (pawn reaching the last rank is stored as a queen).
module pawn_move_exec (
    input  logic              clk,
    input  logic              reset,
    pawn_move_exec_if.slave   bus,
    output logic              turn,
    output logic [3:0]        cap_white,
    output logic [3:0]        cap_black
);

    typedef enum logic [2:0] {IDLE, CHECK, WRITE, CLEAR, RESP} state_t;

    state_t               state, state_next;
    logic [7:0][7:0][4:0] board;
    logic [2:0]           row, col;
    logic [1:0]           dir;
    logic [1:0]           code, code_next;
    logic [2:0]           dst_row, dst_col;
    logic [4:0]           pawn_word;
    logic                 own_pawn, allow_sel, dst_occupied;
    logic                 allow_unused;

    // Piece types: 001 pawn, 010 knight, 011 bishop, 100 rook, 101 queen, 110 king.
    function automatic logic [2:0] back_rank_type(input int c);
        case (c)
            0, 7:    back_rank_type = 3'b100;
            1, 6:    back_rank_type = 3'b010;
            2, 5:    back_rank_type = 3'b011;
            3:       back_rank_type = 3'b101;
            default: back_rank_type = 3'b110;
        endcase
    endfunction

    function automatic logic [7:0][7:0][4:0] start_board();
        logic [7:0][7:0][4:0] b;
        b = '0;
        for (int c = 0; c < 8; c++) begin
            b[0][c] = {back_rank_type(c), 1'b1, 1'b1};
            b[1][c] = {3'b001, 1'b1, 1'b1};
            b[6][c] = {3'b001, 1'b0, 1'b1};
            b[7][c] = {back_rank_type(c), 1'b0, 1'b1};
        end
        return b;
    endfunction

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_code  = code;
    assign bus.chk_row    = row;
    assign bus.chk_col    = col;
    assign bus.chk_color  = turn;
    assign bus.chk_board  = board;
    assign allow_unused   = ^bus.chk_allow[4:3];

    always_comb begin
        dst_row = turn ? row + 3'd1 : row - 3'd1;
        dst_col = col;
        case (dir)
            2'b01:   dst_col = col - 3'd1;
            2'b10:   dst_col = col + 3'd1;
            default: dst_col = col;
        endcase
        own_pawn     = (board[row][col] == {3'b001, turn, 1'b1});
        dst_occupied = board[dst_row][dst_col][0];
        case (dir)
            2'b00:   allow_sel = bus.chk_allow[2];
            2'b01:   allow_sel = bus.chk_allow[1];
            2'b10:   allow_sel = bus.chk_allow[0];
            default: allow_sel = 1'b0;
        endcase
        pawn_word = {3'b001, turn, 1'b1};
`ifdef PAWN_PROMOTE_EN
        if (dst_row == (turn ? 3'd7 : 3'd0)) pawn_word = {3'b101, turn, 1'b1};
`else
`endif
    end

    // Error precedence in CHECK: bad direction, then wrong source, then checker veto.
    always_comb begin
        state_next = state;
        code_next  = code;
        case (state)
            IDLE:  if (bus.req_valid) state_next = CHECK;
            CHECK: begin
                if (dir == 2'b11) begin
                    code_next  = 2'b11;
                    state_next = RESP;
                end else if (!own_pawn) begin
                    code_next  = 2'b01;
                    state_next = RESP;
                end else if (!allow_sel) begin
                    code_next  = 2'b10;
                    state_next = RESP;
                end else begin
                    code_next  = 2'b00;
                    state_next = WRITE;
                end
            end
            WRITE:   state_next = CLEAR;
            CLEAR:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            board     <= start_board();
            turn      <= 1'b0;
            cap_white <= 4'd0;
            cap_black <= 4'd0;
            code      <= 2'b00;
            row       <= 3'd0;
            col       <= 3'd0;
            dir       <= 2'b00;
        end else begin
            state <= state_next;
            code  <= code_next;
            if (state == IDLE && bus.req_valid) begin
                row <= bus.req_row;
                col <= bus.req_col;
                dir <= bus.req_dir;
            end
            // Destination and source go in separate cycles so only one square changes per edge.
            if (state == WRITE) begin
                board[dst_row][dst_col] <= pawn_word;
                if (dst_occupied) begin
                    if (turn) begin
                        if (cap_black != 4'hF) cap_black <= cap_black + 4'd1;
                    end else begin
                        if (cap_white != 4'hF) cap_white <= cap_white + 4'd1;
                    end
                end
            end
            if (state == CLEAR) begin
                board[row][col] <= 5'b00000;
                turn            <= ~turn;
            end
        end
    end

endmodule

// File: tb/tb_pawn_move_exec.sv
// Self-checking bench for pawn_move_exec: directed scenarios plus randomized requests
// compared every cycle against a square-level board model; the bench also acts as the checker.
module tb_pawn_move_exec;

    typedef logic [7:0][7:0][4:0] board_t;
    typedef enum int {P_IDLE, P_CHECK, P_WRITE, P_CLEAR, P_RESP} phase_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       turn;
    logic [3:0] cap_white, cap_black;
    logic [2:0] allow_mask = 3'b111;
    logic [1:0] allow_junk = 2'b00;

    int checks = 0;
    int passes = 0;

    board_t     m_board;
    logic       m_turn;
    int         m_capw, m_capb;
    phase_t     phase = P_IDLE;
    logic [2:0] m_row, m_col;
    logic [1:0] m_dir, m_code;
    logic [2:0] m_allow;
    logic       m_sel;
    int         m_dr, m_dc;
    logic [4:0] m_word;

    always #5 clk = ~clk;

    pawn_move_exec_if bus();

    pawn_move_exec dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .turn      (turn),
        .cap_white (cap_white),
        .cap_black (cap_black)
    );

    function automatic board_t ref_start();
        int     back[8] = '{4, 2, 3, 5, 6, 3, 2, 4};
        board_t b;
        b = '0;
        for (int c = 0; c < 8; c++) begin
            b[0][c] = {3'(back[c]), 2'b11};
            b[1][c] = 5'b00111;
            b[6][c] = 5'b00101;
            b[7][c] = {3'(back[c]), 2'b01};
        end
        return b;
    endfunction

    // Pawn rules: forward needs an empty square, diagonals need an enemy piece.
    function automatic logic [2:0] ref_allow(input board_t b, input int r, input int c, input logic color);
        int         dr;
        logic [2:0] a;
        a  = 3'b000;
        dr = color ? r + 1 : r - 1;
        if (dr < 0 || dr > 7) return 3'b000;
        a[2] = !b[dr][c][0];
        if (c > 0) a[1] = b[dr][c-1][0] && (b[dr][c-1][1] != color);
        if (c < 7) a[0] = b[dr][c+1][0] && (b[dr][c+1][1] != color);
        return a;
    endfunction

    assign bus.chk_allow = {allow_junk,
                            ref_allow(bus.chk_board, int'(bus.chk_row), int'(bus.chk_col), bus.chk_color) & allow_mask};

    task automatic check_output(input string name, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            m_board = ref_start();
            m_turn  = 1'b0;
            m_capw  = 0;
            m_capb  = 0;
            phase   = P_IDLE;
        end else begin
            check_output("turn", turn, m_turn);
            check_output("chk_color", bus.chk_color, m_turn);
            check_output("board", bus.chk_board, m_board);
            check_output("captures", {cap_white, cap_black}, {4'(m_capw), 4'(m_capb)});
            check_output("req_ready", bus.req_ready, phase == P_IDLE);
            check_output("resp_valid", bus.resp_valid, phase == P_RESP);
            case (phase)
                P_IDLE: if (bus.req_valid) begin
                    m_row = bus.req_row;
                    m_col = bus.req_col;
                    m_dir = bus.req_dir;
                    phase = P_CHECK;
                end
                P_CHECK: begin
                    check_output("chk_square", {bus.chk_row, bus.chk_col}, {m_row, m_col});
                    m_allow = ref_allow(m_board, int'(m_row), int'(m_col), m_turn) & allow_mask;
                    m_sel   = (m_dir == 2'd0) ? m_allow[2] : (m_dir == 2'd1) ? m_allow[1] : m_allow[0];
                    if (m_dir == 2'd3) m_code = 2'b11;
                    else if (m_board[m_row][m_col] != {3'b001, m_turn, 1'b1}) m_code = 2'b01;
                    else if (!m_sel) m_code = 2'b10;
                    else m_code = 2'b00;
                    phase = (m_code == 2'b00) ? P_WRITE : P_RESP;
                end
                P_WRITE: begin
                    m_dr   = m_turn ? int'(m_row) + 1 : int'(m_row) - 1;
                    m_dc   = int'(m_col) + ((m_dir == 2'd1) ? -1 : (m_dir == 2'd2) ? 1 : 0);
                    m_word = {3'b001, m_turn, 1'b1};
`ifdef PAWN_PROMOTE_EN
                    if (m_dr == (m_turn ? 7 : 0)) m_word = {3'b101, m_turn, 1'b1};
`else
`endif
                    if (m_dr >= 0 && m_dr < 8 && m_dc >= 0 && m_dc < 8) begin
                        if (m_board[m_dr][m_dc][0]) begin
                            if (m_turn) m_capb = (m_capb < 15) ? m_capb + 1 : 15;
                            else        m_capw = (m_capw < 15) ? m_capw + 1 : 15;
                        end
                        m_board[m_dr][m_dc] = m_word;
                    end
                    phase = P_CLEAR;
                end
                P_CLEAR: begin
                    m_board[m_row][m_col] = 5'b00000;
                    m_turn = ~m_turn;
                    phase  = P_RESP;
                end
                default: begin
                    check_output("resp_code", bus.resp_code, m_code);
                    phase = P_IDLE;
                end
            endcase
        end
    end

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Issues one request from an idle DUT and checks the response code and its latency.
    task automatic apply_stimulus(input int r, input int c, input int d, input logic [2:0] mask,
                                  input logic [1:0] exp_code);
        logic [1:0] code;
        int         lat;
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_row   = 3'(r);
        bus.req_col   = 3'(c);
        bus.req_dir   = 2'(d);
        allow_mask    = mask;
        allow_junk    = 2'($urandom);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat  = -1;
        code = 2'b00;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                code = bus.resp_code;
                lat  = k;
                break;
            end
            @(posedge clk); #1;
        end
        if (lat < 0) begin
            checks++;
            $display("[TB] FAIL resp_timeout: got no resp_valid expected one within 8 cycles");
        end else begin
            check_output("dir_code", code, exp_code);
            check_output("dir_latency", lat, (exp_code == 2'b00) ? 4 : 2);
        end
    endtask

    int seq_r[11] = '{6, 1, 5, 2, 4, 3, 3, 4, 2, 1, 1};
    int seq_c[11] = '{5, 0, 5, 0, 5, 0, 5, 0, 5, 7, 4};
    int seq_d[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2};

    initial begin
        int   r, c, s, start;
        logic got_resp;
        bus.req_valid = 1'b0;
        bus.req_row   = 3'd0;
        bus.req_col   = 3'd0;
        bus.req_dir   = 2'd0;
        apply_reset();
        check_output("rst_turn", turn, 1'b0);
        check_output("rst_ready", bus.req_ready, 1'b1);
        check_output("rst_white_pawn", bus.chk_board[6][4], 5'b00101);

        apply_stimulus(6, 4, 0, 3'b111, 2'b00);
        check_output("fwd_dest", bus.chk_board[5][4], 5'b00101);
        check_output("fwd_src", bus.chk_board[6][4], 5'b00000);
        check_output("fwd_turn", turn, 1'b1);
        apply_stimulus(1, 3, 0, 3'b000, 2'b10);
        check_output("veto_src", bus.chk_board[1][3], 5'b00111);
        check_output("veto_turn", turn, 1'b1);
        apply_stimulus(3, 3, 0, 3'b111, 2'b01);
        apply_stimulus(5, 4, 0, 3'b111, 2'b01);
        apply_stimulus(1, 3, 3, 3'b111, 2'b11);
        @(posedge clk); #1;
        check_output("ready_after_resp", bus.req_ready, 1'b1);

        apply_reset();
        for (int i = 0; i < 11; i++) begin
            apply_stimulus(seq_r[i], seq_c[i], seq_d[i], 3'b111, 2'b00);
            if (i == 8) begin
                check_output("capture_count", cap_white, 4'd1);
                check_output("capture_dest", bus.chk_board[1][4], 5'b00101);
            end
        end
        check_output("second_capture", cap_white, 4'd2);
`ifdef PAWN_PROMOTE_EN
        check_output("last_rank_word", bus.chk_board[0][5], 5'b10101);
`else
        check_output("last_rank_word", bus.chk_board[0][5], 5'b00101);
`endif

        apply_reset();
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_row   = 3'd6;
        bus.req_col   = 3'd4;
        bus.req_dir   = 2'd0;
        allow_mask    = 3'b111;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        got_resp = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.resp_valid) got_resp = 1'b1;
        end
        check_output("abort_no_resp", got_resp, 1'b0);
        check_output("abort_dest", bus.chk_board[5][4], 5'b00000);
        check_output("abort_src", bus.chk_board[6][4], 5'b00101);
        check_output("abort_turn", turn, 1'b0);
        apply_stimulus(6, 4, 0, 3'b111, 2'b00);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            reset = ($urandom_range(0, 99) == 0);
            bus.req_valid = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 7);
            c = $urandom_range(0, 7);
            if ($urandom_range(0, 9) < 7) begin
                start = $urandom_range(0, 63);
                for (int k = 0; k < 64; k++) begin
                    s = (start + k) % 64;
                    if (m_board[s / 8][s % 8] == {3'b001, m_turn, 1'b1}) begin
                        r = s / 8;
                        c = s % 8;
                        break;
                    end
                end
            end
            bus.req_row = 3'(r);
            bus.req_col = 3'(c);
            bus.req_dir = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            allow_mask  = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'b111;
            allow_junk  = 2'($urandom);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        bus.req_valid = 1'b0;
        repeat (8) @(posedge clk);
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pawn_move_exec.md
# pawn_move_exec

Sequential move executor that owns the 8x8 board register and commits pawn moves. It sits directly upstream and downstream of the combinational pawn-move checker: it drives that checker with the board, square and colour, then samples the returned allow vector. A move is committed only if the checker permits it, and the board is updated over fixed cycles. Requests arrive on a valid/ready handshake, and every accepted request produces a single-cycle response.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; loads the start position
- req_valid  in  1  move request present
- req_ready  out  1  high only in IDLE
- req_row  in  3  source row; 0 = top
- req_col  in  3  source column; 0 = left
- req_dir  in  2  00 forward, 01 diagLeft, 10 diagRight, 11 illegal code
- chk_row  out  3  source row to checker (registered)
- chk_col  out  3  source column to checker (registered)
- chk_color  out  1  side to move; 0 white, 1 black
- chk_board  out  5x8x8  board register; bit0 occupied, bit1 colour, bits4:2 type
- chk_allow  in  5  checker result; [2] fwd, [1] diagL, [0] diagR; [4:3] ignored
- resp_valid  out  1  one-cycle pulse per accepted request
- resp_code  out  2  00 ok, 01 source not own pawn, 10 not allowed, 11 bad dir
- turn  out  1  side to move; 0 white
- cap_white  out  4  black pieces captured by white (saturating)
- cap_black  out  4  white pieces captured by black (saturating)

## Operation
- Reset board, rows 0/7 (black/white): columns 0..7 hold rook, knight, bishop, queen, king, bishop, knight, rook. Rows 1/6 hold all pawns. Rows 2-5 hold 5'b00000. Example encodings: white pawn 5'b00101, black pawn 5'b00111.
- Reset outputs: turn=0, counters=0, resp_valid=0, resp_code=00, chk_row=0, chk_col=0, FSM=IDLE.
- chk_color always equals turn.
- IDLE: req_ready=1. On req_valid, latch row/col/dir and go to CHECK.
- CHECK: chk_row/chk_col hold the latched square.
  - dir=11: code 11.
  - Source is not {001, turn, 1}: code 01.
  - Selected chk_allow bit is 0: code 10.
  - Otherwise go to WRITE; on any error go to RESP.
- Destination row: row-1 for white, row+1 for black. Destination column: col for fwd, col-1 for diagL, col+1 for diagR.
- WRITE: if the destination is occupied, increment the mover's capture counter, saturating at 15. Write the pawn word to the destination.
- CLEAR: write 5'b00000 to the source square and toggle turn. Go to RESP.
- RESP: resp_valid=1 with the code, then return to IDLE.
- Rejected moves change no board square, turn or counter.
- At most one board square is written per cycle.

## Timing
- Accept edge = cycle 0. CHECK is cycle 1. chk_allow is combinational from the chk_* registers and is sampled at the end of cycle 1.
- Legal move: destination written at the end of cycle 2, source cleared at the end of cycle 3, resp_valid high in cycle 4 (4-cycle latency).
- Rejected move: resp_valid high in cycle 2.
- req_ready is low from cycle 1 through the RESP cycle. The next request is accepted no earlier than the cycle after RESP.
- reset asserted in any state aborts the move with no response, reloads the board, and returns to IDLE on the next edge.
- req_* inputs are ignored while req_ready=0.

## Configuration
- PAWN_PROMOTE_EN defined: a pawn written into row 0 (white) or row 7 (black) is stored as a queen (type 101) with its own colour.
- PAWN_PROMOTE_EN undefined: the pawn word is stored unchanged, and a pawn on the last rank stays a pawn; the checker then blocks all of its moves.

## Test plan
- Reset, then white fwd from (6,4): resp_code 00 in cycle 4; (5,4)=00101, (6,4)=0, turn=1.
- Black fwd from (1,3) into a square occupied at (2,3): resp_code 10; board and turn unchanged; resp_valid in cycle 2.
- White diagL from (3,2) with a black knight at (2,1): code 00; cap_white=1; (2,1)=00101.
- Request from an empty square, from the opponent's pawn, and with dir=11: codes 01, 01 and 11 respectively; req_ready high again after RESP.
- White pawn at (1,5) fwd with (0,5) empty: (0,5)=10101 with PAWN_PROMOTE_EN, 00101 without.
- Assert reset in the WRITE cycle: no resp_valid, start position restored, turn=0; the next request is accepted normally.
